// File: rtl/enc_pkg.sv
// Shared definitions for the irq_encoder8x3 event encoder.
//   WIDTH   : number of request lines (fixed at 8)
//   CODE_W  : width of a request index
//   code_t  : request index type
//   onehot  : index -> one-hot request mask
package enc_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    function automatic logic [WIDTH-1:0] onehot(input code_t c);
        logic [WIDTH-1:0] m;
        m    = '0;
        m[c] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/irq_encoder8x3_prio_pick.sv
// Combinational wrap-around priority picker.
// Searches vec downward starting at start (start, start-1, ... wrapping
// modulo 8) and returns the first set index.
//   vec   : in,  candidate bit vector
//   start : in,  first index examined
//   idx   : out, first set index found (0 when none)
//   any   : out, at least one bit of vec is set
module prio_pick
    import enc_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    input  code_t            start,
    output code_t            idx,
    output logic             any
);

    code_t w_pos;
    logic  w_found;

    always_comb begin
        idx     = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_pos = start - code_t'(k);
            if (!w_found && vec[w_pos]) begin
                idx     = w_pos;
                w_found = 1'b1;
            end
        end
        any = w_found;
    end

endmodule

// File: rtl/irq_encoder8x3.sv
// Sequential 8-to-3 event encoder.
// Captures rising edges of req into a pending register, picks one pending
// line (fixed priority, 7 highest, or round-robin) and presents its index
// on a registered valid/ready output stage.
//   clk      : in,  clock
//   rst_n    : in,  asynchronous active-low reset
//   enable   : in,  gates edge capture and output loading
//   req      : in,  level request lines (events are rising edges)
//   code     : out, index of the granted request
//   valid    : out, code holds an unconsumed grant
//   ready    : in,  consumer accepts code when valid && ready
//   pending  : out, captured events not yet granted
//   overflow : out, one-cycle pulse when an event is lost
module irq_encoder8x3
    import enc_pkg::*;
#(
    parameter int unsigned RR     = 0,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [WIDTH-1:0]  req,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic [WIDTH-1:0]  pending,
    output logic              overflow
);

    if (WIDTH != 8 || CODE_W != 3) begin : g_bad_size
        $error("irq_encoder8x3 supports only WIDTH=8, CODE_W=3");
    end

    logic [WIDTH-1:0] r_req_q;
    logic [WIDTH-1:0] r_pending;
    code_t            r_code;
    logic             r_valid;
    code_t            r_last;
    logic             r_overflow;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_load_mask;
    code_t            w_start;
    code_t            w_idx;
    logic             w_any;
    logic             w_free;
    logic             w_load;

    assign w_rise  = req & ~r_req_q & {WIDTH{enable}};
    assign w_start = (RR != 0) ? (r_last - code_t'(1)) : code_t'(WIDTH - 1);

    prio_pick u_pick (
        .vec   (r_pending),
        .start (w_start),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign w_free      = ~r_valid | ready;
    assign w_load      = w_free & enable & w_any;
    assign w_load_mask = w_load ? onehot(w_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q    <= '0;
            r_pending  <= '0;
            r_code     <= '0;
            r_valid    <= 1'b0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_req_q    <= req;
            // A rise on the bit being loaded re-arms it; not an overflow.
            r_pending  <= (r_pending & ~w_load_mask) | w_rise;
            r_overflow <= |(w_rise & r_pending & ~w_load_mask);
            if (w_load) begin
                r_code  <= w_idx;
                r_valid <= 1'b1;
                r_last  <= w_idx;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign code     = r_code;
    assign valid    = r_valid;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_irq_encoder8x3.sv
module tb_irq_encoder8x3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       ready;
    logic [7:0] req;

    logic [2:0] code0,  code1;
    logic       valid0, valid1;
    logic [7:0] pend0,  pend1;
    logic       ovf0,   ovf1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_encoder8x3 #(.RR(0), .WIDTH(8), .CODE_W(3)) u_fix (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .code(code0), .valid(valid0), .ready(ready),
        .pending(pend0), .overflow(ovf0)
    );

    irq_encoder8x3 #(.RR(1), .WIDTH(8), .CODE_W(3)) u_rr (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .code(code1), .valid(valid1), .ready(ready),
        .pending(pend1), .overflow(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fixed-priority instance state check.
    task automatic chk0(input string tag, input logic [7:0] p, input logic v,
                        input logic [2:0] c, input logic o);
        check({tag, ".pending"},  32'(pend0),  32'(p));
        check({tag, ".valid"},    32'(valid0), 32'(v));
        check({tag, ".code"},     32'(code0),  32'(c));
        check({tag, ".overflow"}, 32'(ovf0),   32'(o));
    endtask

    logic [2:0] rr_exp [6] = '{3'd6, 3'd3, 3'd1, 3'd6, 3'd3, 3'd1};
    logic [7:0] rr_mask;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        req    = 8'h00;
        step();
        step();
        chk0("reset", 8'h00, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;

        // Single pulse on req[5]
        req = 8'h20;
        step(); chk0("t1.e0", 8'h20, 1'b0, 3'd0, 1'b0);
        req = 8'h00;
        step(); chk0("t1.e1", 8'h00, 1'b1, 3'd5, 1'b0);
        step(); check("t1.drop.valid", 32'(valid0), 32'd0);

        // Fixed priority on 0x91: 7, 4, 0
        req = 8'h91;
        step(); chk0("t2.cap", 8'h91, 1'b0, 3'd5, 1'b0);
        req = 8'h00;
        step(); chk0("t2.g7", 8'h11, 1'b1, 3'd7, 1'b0);
        step(); chk0("t2.g4", 8'h01, 1'b1, 3'd4, 1'b0);
        step(); chk0("t2.g0", 8'h00, 1'b1, 3'd0, 1'b0);
        step(); check("t2.end.valid", 32'(valid0), 32'd0);

        // Overflow with ready low and code 2 held
        ready = 1'b0;
        req = 8'h04;
        step(); chk0("t4.cap", 8'h04, 1'b0, 3'd0, 1'b0);
        req = 8'h00;
        step(); chk0("t4.g2", 8'h00, 1'b1, 3'd2, 1'b0);
        req = 8'h04;
        step(); chk0("t4.rearm", 8'h04, 1'b1, 3'd2, 1'b0);
        req = 8'h00;
        step();
        req = 8'h04;
        step(); chk0("t4.ovf", 8'h04, 1'b1, 3'd2, 1'b1);
        req = 8'h00;
        step(); chk0("t4.post", 8'h04, 1'b1, 3'd2, 1'b0);
        ready = 1'b1;
        step(); chk0("t4.accept", 8'h00, 1'b1, 3'd2, 1'b0);
        step(); check("t4.idle.valid", 32'(valid0), 32'd0);

        // enable low: grant accepted, no capture
        ready = 1'b0;
        req = 8'h02;
        step();
        req = 8'h00;
        step(); chk0("t5.g1", 8'h00, 1'b1, 3'd1, 1'b0);
        enable = 1'b0;
        ready  = 1'b1;
        req    = 8'h08;
        step(); chk0("t5.dis", 8'h00, 1'b0, 3'd1, 1'b0);
        req = 8'h00;
        step(); chk0("t5.dis2", 8'h00, 1'b0, 3'd1, 1'b0);
        enable = 1'b1;
        step(); chk0("t5.en", 8'h00, 1'b0, 3'd1, 1'b0);

        // Asynchronous reset with pending 0xFF and valid high
        ready = 1'b0;
        req = 8'hFF;
        step(); check("t6.cap.pending", 32'(pend0), 32'hFF);
        req = 8'h00;
        step(); chk0("t6.g7", 8'h7F, 1'b1, 3'd7, 1'b0);
        req = 8'hFF;
        step(); chk0("t6.full", 8'hFF, 1'b1, 3'd7, 1'b1);
        req = 8'h01;
        #2 rst_n = 1'b0;
        #1 chk0("t6.async", 8'h00, 1'b0, 3'd0, 1'b0);
        step(); chk0("t6.hold", 8'h00, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        ready = 1'b1;
        step(); chk0("t6.rel1", 8'h01, 1'b0, 3'd0, 1'b0);
        step(); chk0("t6.rel2", 8'h00, 1'b1, 3'd0, 1'b0);

        // Round-robin on bits 1, 3, 6 with granted bit re-pulsed
        rst_n = 1'b0;
        req   = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        req = 8'h4A;
        step(); check("t3.cap.pending", 32'(pend1), 32'h4A);
        req = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t3.grant%0d.valid", i), 32'(valid1), 32'd1);
            check($sformatf("t3.grant%0d.code", i),  32'(code1),  32'(rr_exp[i]));
            rr_mask = 8'h01 << rr_exp[i];
            req = rr_mask;
        end
        check("t3.ovf", 32'(ovf1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
